// File: rtl/clint.sv
// Core-local interrupt controller: sequences trap entry (mepc/mstatus/mcause writes, redirect to mtvec) and mret.
// Optional build macro CLINT_TIMER_IRQ_EN enables the timer interrupt source.
module clint (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_interrupt_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET_MSTATUS, MRET_ASSERT
  } state_t;

  state_t      state;
  logic [31:0] cause_q;
  logic [31:0] mepc_q;
  logic [31:0] wdata_q;

  logic        is_mret, is_ecall, is_ebreak;
  logic        ext_evt, timer_evt, sync_evt, trap_evt, idle_evt;
  logic [31:0] cause_d, mepc_d;

  // Trap entry: save MIE into MPIE and disable interrupts.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[7] = s[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // mret: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

  assign is_mret   = (inst_i == INST_MRET);
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign ext_evt   = irq_ext_i & csr_mstatus_i[3];

`ifdef CLINT_TIMER_IRQ_EN
  assign timer_evt = irq_timer_i & csr_mstatus_i[3];
`else
  logic timer_unused;
  assign timer_unused = irq_timer_i;
  assign timer_evt    = 1'b0;
`endif

  assign sync_evt = is_ecall | is_ebreak;
  assign trap_evt = sync_evt | ext_evt | timer_evt;
  assign idle_evt = ~rst_i & (state == IDLE) & (is_mret | trap_evt);
  assign stall_o  = ~rst_i & ((state != IDLE) | idle_evt);

  always_comb begin
    cause_d = CAUSE_TIMER;
    if (is_ecall)       cause_d = CAUSE_ECALL;
    else if (is_ebreak) cause_d = CAUSE_EBREAK;
    else if (ext_evt)   cause_d = CAUSE_EXT;
  end

  // Async interrupts resume at the pending jump target so a taken branch is not lost.
  assign mepc_d = (!sync_evt && jump_flag_i) ? jump_addr_i : inst_addr_i;

  assign csr_wdata_o = (state == MEPC) ? mepc_q : wdata_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      cause_q           <= '0;
      mepc_q            <= '0;
      wdata_q           <= '0;
      csr_we_o          <= 1'b0;
      csr_waddr_o       <= '0;
      int_assert_o      <= 1'b0;
      flush_interrupt_o <= 1'b0;
      int_addr_o        <= '0;
    end else begin
      csr_we_o          <= 1'b0;
      csr_waddr_o       <= '0;
      wdata_q           <= '0;
      int_assert_o      <= 1'b0;
      flush_interrupt_o <= 1'b0;
      int_addr_o        <= '0;
      unique case (state)
        IDLE: begin
          if (is_mret) begin
            state       <= MRET_MSTATUS;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= ADDR_MSTATUS;
            wdata_q     <= mret_mstatus(csr_mstatus_i);
          end else if (trap_evt) begin
            state       <= MEPC;
            cause_q     <= cause_d;
            mepc_q      <= mepc_d;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= ADDR_MEPC;
          end
        end
        MEPC: begin
          state       <= MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MSTATUS;
          wdata_q     <= trap_mstatus(csr_mstatus_i);
        end
        MSTATUS: begin
          state       <= MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MCAUSE;
          wdata_q     <= cause_q;
        end
        MCAUSE: begin
          state             <= ASSERT;
          int_assert_o      <= 1'b1;
          flush_interrupt_o <= 1'b1;
          int_addr_o        <= csr_mtvec_i;
        end
        MRET_MSTATUS: begin
          state             <= MRET_ASSERT;
          int_assert_o      <= 1'b1;
          flush_interrupt_o <= 1'b1;
          int_addr_o        <= csr_mepc_i;
        end
        ASSERT, MRET_ASSERT: state <= IDLE;
        default:             state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: expected CSR writes and redirect pulses are queued, a negedge monitor checks them.
module tb_clint;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, irq_ext_i, irq_timer_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        csr_we_o, stall_o, flush_interrupt_o, int_assert_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, int_addr_o;

  typedef struct {
    bit          is_assert;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  clint dut (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .stall_o(stall_o), .flush_interrupt_o(flush_interrupt_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  // Monitor: every write or redirect pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (csr_we_o || int_assert_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: we=%0d addr=%h data=%h assert=%0d int_addr=%h, required no activity",
                 csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o);
      end else begin
        e = q.pop_front();
        if (e.is_assert)
          ok = int_assert_o && flush_interrupt_o && !csr_we_o && (int_addr_o == e.data);
        else
          ok = csr_we_o && !int_assert_o && !flush_interrupt_o &&
               (csr_waddr_o == e.addr) && (csr_wdata_o == e.data);
        if (!ok) begin
          errors++;
          $display("FAIL event_match: got we=%0d addr=%h data=%h assert=%0d flush=%0d int_addr=%h, required assert=%0d addr=%h data=%h",
                   csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, flush_interrupt_o, int_addr_o,
                   e.is_assert, e.addr, e.data);
        end
      end
    end else begin
      checks++;
      if (csr_waddr_o != 0 || csr_wdata_o != 0 || int_addr_o != 0 || flush_interrupt_o) begin
        errors++;
        $display("FAIL quiet_outputs: addr=%h data=%h int_addr=%h flush=%0d, required all 0",
                 csr_waddr_o, csr_wdata_o, int_addr_o, flush_interrupt_o);
      end
    end
  end

  task automatic push_trap(input logic [31:0] mepc, input logic [31:0] mst,
                           input logic [31:0] cause, input logic [31:0] mtvec);
    q.push_back('{1'b0, 12'h341, mepc});
    q.push_back('{1'b0, 12'h300, mst});
    q.push_back('{1'b0, 12'h342, cause});
    q.push_back('{1'b1, 12'h000, mtvec});
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic clear_inputs();
    inst_i = NOP; irq_ext_i = 1'b0; irq_timer_i = 1'b0; jump_flag_i = 1'b0;
  endtask

  // Runs n cycles from the event cycle, counting stall; instruction is dropped after
  // the first cycle, interrupts/jump after hold+1 cycles.
  task automatic run_window(input string name, input int n, input int hold, input int exp_stall);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stall_o) s++;
      @(posedge clk); #1;
      if (i == 0) inst_i = NOP;
      if (i == hold) begin irq_ext_i = 1'b0; irq_timer_i = 1'b0; jump_flag_i = 1'b0; end
    end
    check_val({name, "_stall_cycles"}, s, exp_stall);
    check_val({name, "_queue_drained"}, q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string name);
    check_val({name, "_we"}, {31'b0, csr_we_o}, 0);
    check_val({name, "_waddr"}, {20'b0, csr_waddr_o}, 0);
    check_val({name, "_wdata"}, csr_wdata_o, 0);
    check_val({name, "_stall"}, {31'b0, stall_o}, 0);
    check_val({name, "_flush"}, {31'b0, flush_interrupt_o}, 0);
    check_val({name, "_assert"}, {31'b0, int_assert_o}, 0);
    check_val({name, "_int_addr"}, int_addr_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    inst_addr_i = 32'h0; jump_addr_i = 32'h0;
    csr_mtvec_i = 32'h80; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    inst_i = ECALL;
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("reset");
    inst_i = NOP;
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1;

    // ecall: mstatus 0x8 -> 0x80, cause 11
    inst_addr_i = 32'h100; csr_mstatus_i = 32'h8;
    push_trap(32'h100, 32'h80, 32'd11, 32'h80);
    inst_i = ECALL;
    run_window("ecall", 10, 0, 5);

    // ebreak with MIE=0 still taken: mstatus 0x0 stays 0x0
    inst_addr_i = 32'h40; csr_mstatus_i = 32'h0; csr_mtvec_i = 32'h1000;
    push_trap(32'h40, 32'h0, 32'd3, 32'h1000);
    inst_i = EBREAK;
    run_window("ebreak", 10, 0, 5);

    // external irq during taken jump: mepc is the jump target
    inst_addr_i = 32'h300; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
    push_trap(32'h200, 32'h80, 32'h8000_000B, 32'h80);
    irq_ext_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
    run_window("irq_ext", 10, 0, 5);

    // same with MIE=0: nothing happens
    csr_mstatus_i = 32'h0;
    irq_ext_i = 1'b1; jump_flag_i = 1'b1;
    run_window("irq_masked", 8, 0, 0);

    // mret: mstatus 0x80 -> 0x88, redirect to mepc
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    q.push_back('{1'b0, 12'h300, 32'h88});
    q.push_back('{1'b1, 12'h000, 32'h104});
    inst_i = MRET;
    run_window("mret", 8, 0, 3);

    // ecall wins over pending interrupts; level irq taken on return to IDLE
    inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h80;
    push_trap(32'h100, 32'h80, 32'd11, 32'h80);
    push_trap(32'h100, 32'h80, 32'h8000_000B, 32'h80);
    inst_i = ECALL; irq_ext_i = 1'b1; irq_timer_i = 1'b1;
    run_window("priority", 14, 5, 10);

    // timer interrupt only honoured when the feature is built in
    inst_addr_i = 32'h500; csr_mstatus_i = 32'h8;
`ifdef CLINT_TIMER_IRQ_EN
    push_trap(32'h500, 32'h80, 32'h8000_0007, 32'h80);
    irq_timer_i = 1'b1;
    run_window("irq_timer", 10, 0, 5);
`else
    irq_timer_i = 1'b1;
    run_window("irq_timer", 10, 0, 0);
`endif

    // reset during MSTATUS aborts the trap
    inst_addr_i = 32'h100; csr_mstatus_i = 32'h8;
    q.push_back('{1'b0, 12'h341, 32'h100});
    inst_i = ECALL;
    @(posedge clk); #1 inst_i = NOP;
    @(posedge clk); #1 rst_i = 1'b1;
    #1 check_zero_outputs("mid_reset");
    @(posedge clk); #1 rst_i = 1'b0;
    run_window("after_reset", 8, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
